// File: rtl/mem_cache_ctrl.sv
// mem_cache_ctrl: direct-mapped write-through, no-write-allocate word cache in front of the SRAM controller.
// Define CACHE_STATS_EN to add the hit_count/miss_count statistics ports.
module mem_cache_ctrl #(
    parameter int ADDR_W     = 19,
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic        sram_wr_en,
    output logic        sram_rd_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_writeData,
    input  logic [31:0] sram_readData,
    input  logic        sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;
    typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;
    state_t                  state_q, state_d;
    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [31:0]             data_q [LINES];
    logic [INDEX_BITS-1:0]   idx;
    logic [TAG_W-1:0]        tag;
    logic                    hit, ready_c;
    assign idx            = address[INDEX_BITS+1:2];
    assign tag            = address[ADDR_W-1:INDEX_BITS+2];
    assign hit            = valid_q[idx] && (tag_q[idx] == tag);
    assign readData       = data_q[idx];
    assign sram_address   = address;
    assign sram_writeData = writeData;
    // Reset forces ready high immediately, even while a load is still held.
    assign ready          = ready_c || !rst_n;
    always_comb begin
        state_d    = state_q;
        ready_c    = 1'b1;
        sram_rd_en = 1'b0;
        sram_wr_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    state_d = WRITE;
                    ready_c = 1'b0;
                end else if (rd_en && !hit) begin
                    state_d = FILL;
                    ready_c = 1'b0;
                end
            end
            FILL: begin
                sram_rd_en = 1'b1;
                ready_c    = 1'b0;
                state_d    = sram_ready ? IDLE : FILL;
            end
            WRITE: begin
                sram_wr_en = 1'b1;
                ready_c    = 1'b0;
                state_d    = sram_ready ? WDONE : WRITE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == FILL && sram_ready) begin
                valid_q[idx] <= 1'b1;
                tag_q[idx]   <= tag;
                data_q[idx]  <= sram_readData;
            end else if (state_q == WRITE && sram_ready && hit) begin
                data_q[idx]  <= writeData;
            end
        end
    end
`ifdef CACHE_STATS_EN
    logic [31:0] hit_q, miss_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (state_q == IDLE && rd_en && !wr_en && hit) hit_q <= hit_q + 32'd1;
            if (state_q == IDLE && state_d == FILL) miss_q <= miss_q + 32'd1;
        end
    end
    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`endif
endmodule

// File: tb/tb_mem_cache_ctrl.sv
// tb_mem_cache_ctrl: directed bench for mem_cache_ctrl with a fixed-latency SRAM controller model
// and a scoreboard of expected load data; honours CACHE_STATS_EN when defined.
module tb_mem_cache_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] address = '0, writeData = '0;
    logic [31:0] readData, sram_address, sram_writeData, sram_readData;
    logic        ready, sram_wr_en, sram_rd_en;
    logic        sram_ready;
    int          errors = 0, checks = 0;
    logic [31:0] exp_q [$];
    logic [31:0] ref_mem  [0:1023];
    logic [31:0] sram_mem [0:1023];
    int          cnt;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count, hit_before;
`endif
    mem_cache_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .writeData(writeData), .readData(readData), .ready(ready),
        .sram_wr_en(sram_wr_en), .sram_rd_en(sram_rd_en), .sram_address(sram_address),
        .sram_writeData(sram_writeData), .sram_readData(sram_readData), .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );
    always #5 clk = ~clk;
    // SRAM controller model: ready pulses in the 4th enabled cycle, writes commit on that pulse.
    assign sram_readData = sram_mem[sram_address[11:2]];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 0;
            sram_ready <= 1'b0;
        end else if (sram_ready) begin
            cnt        <= 0;
            sram_ready <= 1'b0;
            if (sram_wr_en) sram_mem[sram_address[11:2]] <= sram_writeData;
        end else if (sram_rd_en || sram_wr_en) begin
            cnt <= cnt + 1;
            if (cnt == 2) sram_ready <= 1'b1;
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic access(input logic is_wr, input logic is_rd, input logic [31:0] a,
                          input logic [31:0] d, input int exp_stall, input int exp_rd,
                          input int exp_wr, input string tag);
        int stall = 0, rdc = 0, wrc = 0;
        bit done = 0;
        @(posedge clk); #1;
        address = a; writeData = d; wr_en = is_wr; rd_en = is_rd;
        if (is_wr) ref_mem[a[11:2]] = d;
        else exp_q.push_back(ref_mem[a[11:2]]);
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            rdc += int'(sram_rd_en);
            wrc += int'(sram_wr_en);
            if (ready) done = 1;
            else begin
                stall++;
                @(posedge clk); #1;
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        if (!is_wr && done) chk({tag, "_data"}, readData, exp_q.pop_front());
        if (is_wr) chk({tag, "_wdone_en"}, {30'd0, sram_wr_en, sram_rd_en}, 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
        chk({tag, "_rd_cycles"}, 32'(rdc), 32'(exp_rd));
        chk({tag, "_wr_cycles"}, 32'(wrc), 32'(exp_wr));
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask
    initial begin
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i]  = 32'hA500_0000 + 32'(i);
            sram_mem[i] = 32'hA500_0000 + 32'(i);
        end
        ref_mem[16]  = 32'hDEADBEEF;
        sram_mem[16] = 32'hDEADBEEF;
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_sram_en", {30'd0, sram_wr_en, sram_rd_en}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        access(1'b0, 1'b1, 32'h40, 32'h0, 5, 4, 0, "t1_cold");
`ifdef CACHE_STATS_EN
        hit_before = hit_count;
`endif
        access(1'b0, 1'b1, 32'h40, 32'h0, 0, 0, 0, "t2_hit");
`ifdef CACHE_STATS_EN
        chk("t2_miss_count", miss_count, 32'd1);
        chk("t2_hit_delta", hit_count - hit_before, 32'd1);
`endif
        access(1'b1, 1'b0, 32'h40, 32'h12345678, 5, 0, 4, "t3_store");
        access(1'b0, 1'b1, 32'h40, 32'h0, 0, 0, 0, "t3_load_hit");
        access(1'b1, 1'b0, 32'h80, 32'h0BADCAFE, 5, 0, 4, "t4_store_miss");
        access(1'b0, 1'b1, 32'h80, 32'h0, 5, 4, 0, "t4_load_miss");
        access(1'b0, 1'b1, 32'h40, 32'h0, 0, 0, 0, "t5_hit");
        access(1'b0, 1'b1, 32'h140, 32'h0, 5, 4, 0, "t5_evict");
        access(1'b0, 1'b1, 32'h40, 32'h0, 5, 4, 0, "t5_refill");
        // Reset arrives in the middle of a fill of a cold line.
        @(posedge clk); #1;
        address = 32'h100; rd_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_in_fill", {31'd0, sram_rd_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_rd_en", {31'd0, sram_rd_en}, 32'd0);
        chk("t6_async_ready", {31'd0, ready}, 32'd1);
        rd_en = 1'b0;
        #3 rst_n = 1'b1;
        access(1'b0, 1'b1, 32'h140, 32'h0, 5, 4, 0, "t6_after_rst");
        access(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 5, 0, 4, "t6_wr_prio");
        access(1'b0, 1'b1, 32'h40, 32'h0, 5, 4, 0, "t6_load_back");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
